connect_recv_endpoint: RTL and testbench

CONNECT_RECV_ENDPOINT -- requirements
Module: connect_recv_endpoint

---
 rtl/connect_recv_pkg.sv | 34 +++
 rtl/connect_vc_fifo.sv | 64 ++++++
 rtl/connect_recv_endpoint.sv | 225 ++++++++++++++++++++++
 tb/tb_connect_recv_endpoint.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/connect_recv_pkg.sv
// Shared definitions for the CONNECT receive endpoint: flit field layout helpers
// and the output arbiter state encoding.
package connect_recv_pkg;

  localparam int FLIT_CTRL_BITS = 2;
  localparam int DATA_LSB       = 0;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  // Flit layout, MSB first: {valid, tail, dest, vc, data}
  function automatic int flit_width(input int dest_bits, input int vc_bits, input int data_w);
    return FLIT_CTRL_BITS + dest_bits + vc_bits + data_w;
  endfunction

  function automatic int vc_lsb(input int data_w);
    return DATA_LSB + data_w;
  endfunction

  function automatic int dest_lsb(input int data_w, input int vc_bits);
    return vc_lsb(data_w) + vc_bits;
  endfunction

  function automatic int tail_bit(input int data_w, input int vc_bits, input int dest_bits);
    return dest_lsb(data_w, vc_bits) + dest_bits;
  endfunction

  function automatic int valid_bit(input int data_w, input int vc_bits, input int dest_bits);
    return tail_bit(data_w, vc_bits, dest_bits) + 1;
  endfunction

endpackage

// File: rtl/connect_vc_fifo.sv
// Per-VC first-word-fall-through buffer. The credit output is high while at
// least two slots are free, leaving one slot for a flit already in flight.
module connect_vc_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic             credit
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_fire, rd_fire;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign credit  = (int'(count_q) <= DEPTH - 2);
  assign rd_data = mem_q[rd_ptr_q];
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: contents are only observable through a non-zero count.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/connect_recv_endpoint.sv
// Receive endpoint: filters and buffers network flits per VC and presents them to
// the user through a wormhole-locking arbiter. Counters exist only with CONNECT_RECV_STATS_EN.
module connect_recv_endpoint
  import connect_recv_pkg::*;
#(
  parameter int NUM_VCS         = 2,
  parameter int VC_BITS         = 1,
  parameter int DEST_BITS       = 2,
  parameter int FLIT_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int MY_ID           = 0,
  localparam int FLIT_W         = flit_width(DEST_BITS, VC_BITS, FLIT_DATA_WIDTH)
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [FLIT_W-1:0]          flit_in,
  output logic                       get_flit_en,
  output logic [NUM_VCS-1:0]         nonfull_vcs,
  output logic                       nonfull_vcs_en,
  output logic                       usr_valid,
  input  logic                       usr_ready,
  output logic [FLIT_DATA_WIDTH-1:0] usr_data,
  output logic [VC_BITS-1:0]         usr_vc,
  output logic                       usr_tail,
  output logic                       dest_err,
  output logic                       ovf_err,
  output logic [31:0]                flit_cnt,
  output logic [31:0]                pkt_cnt
);

  localparam int VC_LSB    = vc_lsb(FLIT_DATA_WIDTH);
  localparam int DEST_LSB  = dest_lsb(FLIT_DATA_WIDTH, VC_BITS);
  localparam int TAIL_BIT  = tail_bit(FLIT_DATA_WIDTH, VC_BITS, DEST_BITS);
  localparam int VALID_BIT = valid_bit(FLIT_DATA_WIDTH, VC_BITS, DEST_BITS);
  localparam int ENTRY_W   = FLIT_DATA_WIDTH + 1;

  logic                       in_valid, in_tail;
  logic [DEST_BITS-1:0]       in_dest;
  logic [VC_BITS-1:0]         in_vc;
  logic [FLIT_DATA_WIDTH-1:0] in_data;
  logic                       dest_ok, vc_ok, tgt_full, accept;
  logic                       set_dest_err, set_ovf_err;

  logic [NUM_VCS-1:0] fifo_wr, fifo_rd, fifo_empty, fifo_full, fifo_credit;
  logic [ENTRY_W-1:0] fifo_dout [NUM_VCS];

  arb_state_e         state_q, state_d;
  logic [VC_BITS-1:0] lock_vc_q, lock_vc_d;
  logic [VC_BITS-1:0] last_vc_q, last_vc_d;
  logic               hold_q, hold_d;
  logic [VC_BITS-1:0] hold_vc_q, hold_vc_d;
  logic               dest_err_q, dest_err_d;
  logic               ovf_err_q, ovf_err_d;

  logic               hi_found, lo_found, scan_found;
  logic [VC_BITS-1:0] hi_vc, lo_vc, scan_vc, sel_vc;
  logic               sel_empty;
  logic [ENTRY_W-1:0] sel_dout;
  logic               xfer;

  assign in_valid = flit_in[VALID_BIT];
  assign in_tail  = flit_in[TAIL_BIT];
  assign in_dest  = flit_in[DEST_LSB +: DEST_BITS];
  assign in_vc    = flit_in[VC_LSB +: VC_BITS];
  assign in_data  = flit_in[DATA_LSB +: FLIT_DATA_WIDTH];

  assign dest_ok = (in_dest == DEST_BITS'(MY_ID));
  assign vc_ok   = (int'(in_vc) < NUM_VCS);

  // Fullness is taken from registered occupancy, so a same-cycle dequeue never frees a slot.
  always_comb begin
    tgt_full = 1'b0;
    for (int v = 0; v < NUM_VCS; v++) begin
      if (in_vc == VC_BITS'(v)) tgt_full = fifo_full[v];
    end
  end

  assign accept       = in_valid && dest_ok && vc_ok && !tgt_full;
  assign set_dest_err = in_valid && !dest_ok;
  assign set_ovf_err  = in_valid && dest_ok && (!vc_ok || tgt_full);

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    assign fifo_wr[v] = accept && (in_vc == VC_BITS'(v));
    assign fifo_rd[v] = xfer && (sel_vc == VC_BITS'(v));

    connect_vc_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (CLK),
      .rst_n   (RST_N),
      .wr_en   (fifo_wr[v]),
      .wr_data ({in_tail, in_data}),
      .rd_en   (fifo_rd[v]),
      .rd_data (fifo_dout[v]),
      .empty   (fifo_empty[v]),
      .full    (fifo_full[v]),
      .credit  (fifo_credit[v])
    );
  end

  // Round-robin scan: lowest non-empty VC above the last grant, else lowest at or below it.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_vc    = '0;
    lo_vc    = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      if (!fifo_empty[v]) begin
        if (v > int'(last_vc_q)) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_vc    = VC_BITS'(v);
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_vc    = VC_BITS'(v);
        end
      end
    end
    scan_found = hi_found || lo_found;
    scan_vc    = hi_found ? hi_vc : lo_vc;
  end

  // A stalled choice in IDLE is held so the presented flit cannot switch VCs.
  always_comb begin
    if (state_q == ARB_LOCK)  sel_vc = lock_vc_q;
    else if (hold_q)          sel_vc = hold_vc_q;
    else                      sel_vc = scan_vc;
    sel_empty = 1'b1;
    sel_dout  = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      if (sel_vc == VC_BITS'(v)) begin
        sel_empty = fifo_empty[v];
        sel_dout  = fifo_dout[v];
      end
    end
  end

  assign usr_valid = !sel_empty && (state_q == ARB_LOCK || hold_q || scan_found);
  assign usr_data  = sel_dout[FLIT_DATA_WIDTH-1:0];
  assign usr_tail  = sel_dout[FLIT_DATA_WIDTH];
  assign usr_vc    = sel_vc;
  assign xfer      = usr_valid && usr_ready;

  always_comb begin
    state_d    = state_q;
    lock_vc_d  = lock_vc_q;
    last_vc_d  = last_vc_q;
    hold_d     = hold_q;
    hold_vc_d  = hold_vc_q;
    dest_err_d = dest_err_q | set_dest_err;
    ovf_err_d  = ovf_err_q | set_ovf_err;
    if (xfer) begin
      last_vc_d = sel_vc;
      hold_d    = 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (!usr_tail) begin
            state_d   = ARB_LOCK;
            lock_vc_d = sel_vc;
          end
        end
        ARB_LOCK: if (usr_tail) state_d = ARB_IDLE;
        default:  state_d = ARB_IDLE;
      endcase
    end else if (state_q == ARB_IDLE && usr_valid) begin
      hold_d    = 1'b1;
      hold_vc_d = sel_vc;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ARB_IDLE;
      lock_vc_q  <= '0;
      last_vc_q  <= VC_BITS'(NUM_VCS - 1);
      hold_q     <= 1'b0;
      hold_vc_q  <= '0;
      dest_err_q <= 1'b0;
      ovf_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_vc_q  <= lock_vc_d;
      last_vc_q  <= last_vc_d;
      hold_q     <= hold_d;
      hold_vc_q  <= hold_vc_d;
      dest_err_q <= dest_err_d;
      ovf_err_q  <= ovf_err_d;
    end
  end

  assign dest_err       = dest_err_q;
  assign ovf_err        = ovf_err_q;
  assign get_flit_en    = RST_N;
  assign nonfull_vcs_en = RST_N;
  assign nonfull_vcs    = fifo_credit & {NUM_VCS{RST_N}};

`ifdef CONNECT_RECV_STATS_EN
  logic [31:0] flit_cnt_q, flit_cnt_d;
  logic [31:0] pkt_cnt_q, pkt_cnt_d;

  always_comb begin
    flit_cnt_d = flit_cnt_q + (accept ? 32'd1 : 32'd0);
    pkt_cnt_d  = pkt_cnt_q + ((xfer && usr_tail) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      flit_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      flit_cnt_q <= flit_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign flit_cnt = flit_cnt_q;
  assign pkt_cnt  = pkt_cnt_q;
`else
  assign flit_cnt = '0;
  assign pkt_cnt  = '0;
`endif

endmodule

// File: tb/tb_connect_recv_endpoint.sv
// Bench for connect_recv_endpoint (NUM_VCS=2, FIFO_DEPTH=4, MY_ID=1, 32-bit data).
module tb_connect_recv_endpoint;

  localparam int NUM_VCS = 2;
  localparam int VC_BITS = 1;
  localparam int DEST_BITS = 2;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int MY_ID = 1;
  localparam int FLIT_W = 2 + DEST_BITS + VC_BITS + DW;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic [FLIT_W-1:0] flit_in = '0;
  logic              usr_ready = 1'b0;
  logic              get_flit_en, nonfull_vcs_en, usr_valid, usr_tail, dest_err, ovf_err;
  logic [NUM_VCS-1:0] nonfull_vcs;
  logic [DW-1:0]     usr_data;
  logic [VC_BITS-1:0] usr_vc;
  logic [31:0]       flit_cnt, pkt_cnt;

  always #5 CLK = ~CLK;

  connect_recv_endpoint #(
    .NUM_VCS(NUM_VCS), .VC_BITS(VC_BITS), .DEST_BITS(DEST_BITS),
    .FLIT_DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MY_ID(MY_ID)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .flit_in(flit_in), .get_flit_en(get_flit_en),
    .nonfull_vcs(nonfull_vcs), .nonfull_vcs_en(nonfull_vcs_en),
    .usr_valid(usr_valid), .usr_ready(usr_ready), .usr_data(usr_data),
    .usr_vc(usr_vc), .usr_tail(usr_tail), .dest_err(dest_err), .ovf_err(ovf_err),
    .flit_cnt(flit_cnt), .pkt_cnt(pkt_cnt)
  );

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];
  int exp_flit_cnt = 0;
  int exp_pkt_cnt = 0;
  logic exp_derr = 1'b0;
  logic exp_ovf = 1'b0;

  typedef struct {
    logic        tail;
    logic [1:0]  dest;
    logic        vc;
    logic [31:0] data;
    bit          deliver;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mk_flit(input logic tail, input logic [1:0] dest,
                                                input logic vc, input logic [31:0] data);
    return {1'b1, tail, dest, vc, data};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Drives one flit for one cycle; optionally records it as expected in input order.
  task automatic send(input logic tail, input logic [1:0] dest, input logic vc,
                      input logic [31:0] data, input bit expect_ok);
    flit_in = mk_flit(tail, dest, vc, data);
    if (dest != 2'(MY_ID)) exp_derr = 1'b1;
    if (expect_ok) begin
      exp_q.push_back({vc, tail, data});
      exp_flit_cnt++;
    end
    @(posedge CLK);
    #1;
    flit_in = '0;
  endtask

  task automatic check_stats(input string tag);
`ifdef CONNECT_RECV_STATS_EN
    check({tag, "_flit_cnt"}, flit_cnt, exp_flit_cnt);
    check({tag, "_pkt_cnt"}, pkt_cnt, exp_pkt_cnt);
`else
    check({tag, "_flit_cnt"}, flit_cnt, 0);
    check({tag, "_pkt_cnt"}, pkt_cnt, 0);
`endif
  endtask

  // Output monitor: pops the scoreboard on every transfer and checks stall stability.
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [33:0] prev_out = '0;
  logic [33:0] mon_e;

  always @(negedge CLK) begin
    if (!RST_N) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        check("stall_valid", usr_valid, 1);
        check("stall_data", {usr_vc, usr_tail, usr_data}, prev_out);
      end
      if (usr_valid && usr_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got 0x%0h expected no output", {usr_vc, usr_tail, usr_data});
        end else begin
          mon_e = exp_q.pop_front();
          check("out_flit", {usr_vc, usr_tail, usr_data}, mon_e);
          if (mon_e[32]) exp_pkt_cnt++;
        end
      end
      prev_valid = usr_valid;
      prev_ready = usr_ready;
      prev_out   = {usr_vc, usr_tail, usr_data};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int budget;
    logic t;

    tbl[0] = '{1'b1, 2'd1, 1'b0, 32'h0000_1000, 1'b1};
    tbl[1] = '{1'b1, 2'd1, 1'b1, 32'h0000_2001, 1'b1};
    tbl[2] = '{1'b1, 2'd2, 1'b0, 32'hDEAD_0002, 1'b0};
    tbl[3] = '{1'b0, 2'd1, 1'b1, 32'h0000_3003, 1'b1};
    tbl[4] = '{1'b1, 2'd1, 1'b1, 32'h0000_4004, 1'b1};
    tbl[5] = '{1'b1, 2'd0, 1'b1, 32'hBAD0_0005, 1'b0};
    tbl[6] = '{1'b1, 2'd1, 1'b0, 32'hFFFF_FFFF, 1'b1};
    tbl[7] = '{1'b1, 2'd3, 1'b1, 32'h0BAD_0007, 1'b0};
    tbl[8] = '{1'b1, 2'd1, 1'b1, 32'h0000_0000, 1'b1};
    tbl[9] = '{1'b1, 2'd1, 1'b0, 32'h5A5A_A5A5, 1'b1};

    // Reset state
    tick(2);
    check("rst_get_flit_en", get_flit_en, 0);
    check("rst_nonfull_en", nonfull_vcs_en, 0);
    check("rst_nonfull_vcs", nonfull_vcs, 2'b00);
    check("rst_usr_valid", usr_valid, 0);
    check("rst_dest_err", dest_err, 0);
    check("rst_ovf_err", ovf_err, 0);
    check_stats("rst");
    RST_N = 1'b1;
    #1;
    check("rel_get_flit_en", get_flit_en, 1);
    check("rel_nonfull_en", nonfull_vcs_en, 1);
    check("rel_nonfull_vcs", nonfull_vcs, 2'b11);
    tick(1);

    // Single tail flit, latency 1
    usr_ready = 1'b0;
    flit_in = mk_flit(1'b1, 2'd1, 1'b0, 32'hA);
    exp_q.push_back({1'b0, 1'b1, 32'hA});
    exp_flit_cnt++;
    #2;
    check("lat_valid_same_cycle", usr_valid, 0);
    @(posedge CLK);
    #1;
    flit_in = '0;
    check("single_valid", usr_valid, 1);
    check("single_data", usr_data, 32'hA);
    check("single_tail", usr_tail, 1);
    check("single_vc", usr_vc, 0);
    usr_ready = 1'b1;
    tick(1);
    usr_ready = 1'b0;
    check("single_done_valid", usr_valid, 0);
    check_stats("single");

    // Fill vc0 with consumer stalled: credit drops at occupancy 3, fifth flit overflows
    for (int k = 0; k < 4; k++) begin
      send(1'b1, 2'd1, 1'b0, 32'h11 + k, 1'b1);
      check("fill_nonfull_vc0", nonfull_vcs[0], (k < 2) ? 1 : 0);
      check("fill_nonfull_vc1", nonfull_vcs[1], 1);
      check("fill_ovf_err", ovf_err, 0);
    end
    send(1'b1, 2'd1, 1'b0, 32'h15, 1'b0);
    exp_ovf = 1'b1;
    check("ovf_err_set", ovf_err, exp_ovf);
    check("ovf_head_data", usr_data, 32'h11);
    // Full at cycle start: dropped even though the head dequeues in the same cycle
    usr_ready = 1'b1;
    send(1'b1, 2'd1, 1'b0, 32'h16, 1'b0);
    tick(6);
    usr_ready = 1'b0;
    check("ovf_drained", exp_q.size(), 0);
    check("ovf_idle_valid", usr_valid, 0);
    check_stats("ovf");

    // Misrouted flit
    check("derr_before", dest_err, 0);
    send(1'b1, 2'd2, 1'b0, 32'h77, 1'b0);
    check("derr_set", dest_err, exp_derr);
    check("derr_no_valid0", usr_valid, 0);
    tick(1);
    check("derr_no_valid1", usr_valid, 0);

    // Wormhole lock: vc0 head, vc1 tail, vc0 tail -> 0x1, 0x3, 0x2
    usr_ready = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 32'h1});
    exp_q.push_back({1'b0, 1'b1, 32'h3});
    exp_q.push_back({1'b1, 1'b1, 32'h2});
    exp_flit_cnt += 3;
    send(1'b0, 2'd1, 1'b0, 32'h1, 1'b0);
    send(1'b1, 2'd1, 1'b1, 32'h2, 1'b0);
    check("lock_empty_no_valid", usr_valid, 0);
    send(1'b1, 2'd1, 1'b0, 32'h3, 1'b0);
    tick(5);
    check("lock_drained", exp_q.size(), 0);
    check("lock_idle_valid", usr_valid, 0);

    // Table-driven back-to-back flits with consumer always ready
    for (int i = 0; i < 10; i++) begin
      send(tbl[i].tail, tbl[i].dest, tbl[i].vc, tbl[i].data, tbl[i].deliver);
      check("tbl_dest_err", dest_err, exp_derr);
      check("tbl_ovf_err", ovf_err, exp_ovf);
      check("tbl_nonfull", nonfull_vcs, 2'b11);
    end
    tick(4);
    check("tbl_drained", exp_q.size(), 0);
    check_stats("tbl");

    // Random credit-respecting stream on vc1 with random consumer backpressure
    sent = 0;
    budget = 0;
    while (sent < 30 && budget < 2000) begin
      usr_ready = 1'($urandom_range(0, 1));
      budget++;
      if (nonfull_vcs[1]) begin
        t = (sent == 29) ? 1'b1 : 1'($urandom_range(0, 1));
        send(t, 2'd1, 1'b1, $urandom, 1'b1);
        sent++;
      end else begin
        tick(1);
      end
    end
    check("rand_sent", sent, 30);
    usr_ready = 1'b1;
    tick(10);
    check("rand_drained", exp_q.size(), 0);
    check_stats("rand");

    // Reset mid-stream with two flits buffered
    usr_ready = 1'b0;
    send(1'b1, 2'd1, 1'b0, 32'h81, 1'b1);
    send(1'b1, 2'd1, 1'b1, 32'h82, 1'b1);
    check("pre_rst_valid", usr_valid, 1);
    #3;
    RST_N = 1'b0;
    #1;
    exp_q.delete();
    exp_flit_cnt = 0;
    exp_pkt_cnt = 0;
    exp_derr = 1'b0;
    exp_ovf = 1'b0;
    check("midrst_valid", usr_valid, 0);
    check("midrst_nonfull", nonfull_vcs, 2'b00);
    check("midrst_get_flit_en", get_flit_en, 0);
    check("midrst_dest_err", dest_err, 0);
    check("midrst_ovf_err", ovf_err, 0);
    check_stats("midrst");
    tick(2);
    RST_N = 1'b1;
    #1;
    check("postrst_nonfull", nonfull_vcs, 2'b11);
    tick(3);
    check("postrst_valid", usr_valid, 0);
    usr_ready = 1'b1;
    send(1'b1, 2'd1, 1'b1, 32'h99, 1'b1);
    tick(3);
    check("postrst_drained", exp_q.size(), 0);
    check_stats("postrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
